// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - N-channel complementary PWM with dead time, centre/edge carrier,
// latched fault shutdown and cycle-start/top pulses for ADC triggering.
module pwm_multi #(
  parameter int               N_CH     = 3,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] MIN_DEAD = 16'd63,
  parameter logic [WIDTH-1:0] MIN_TOP  = 16'd2
) (
  input  logic                  c,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      w_top,
  input  logic                  mode,
  input  logic [N_CH*WIDTH-1:0] duty,
  input  logic [N_CH-1:0]       en,
  input  logic [WIDTH-1:0]      dead,
  input  logic                  fault,
  input  logic                  fault_clr,
  output logic [N_CH-1:0]       hi,
  output logic [N_CH-1:0]       lo,
  output logic [WIDTH-1:0]      w,
  output logic                  cyc_start,
  output logic                  cyc_top,
  output logic                  faulted
);

  logic [WIDTH-1:0]      r_w;
  logic                  r_dir;
  logic [WIDTH-1:0]      r_top;
  logic                  r_mode;
  logic [N_CH*WIDTH-1:0] r_duty;
  logic [N_CH-1:0]       r_en;
  logic [WIDTH-1:0]      r_dead;
  logic [N_CH-1:0]       r_hi;
  logic [N_CH-1:0]       r_lo;
  logic                  r_faulted;

  logic                  w_load;
  logic [WIDTH-1:0]      w_top_clamp;
  logic [WIDTH-1:0]      w_dead_clamp;
  logic [WIDTH-1:0]      w_top_eff;
  logic                  w_mode_eff;
  logic                  w_dir_eff;
  logic [WIDTH-1:0]      w_w_next;
  logic                  w_dir_next;
  logic [N_CH-1:0]       w_hi_c;
  logic [N_CH-1:0]       w_lo_c;

  assign w_load       = (r_w == '0);
  assign w_top_clamp  = (w_top < MIN_TOP) ? MIN_TOP : w_top;
  assign w_dead_clamp = (dead < MIN_DEAD) ? MIN_DEAD : dead;

  // At a cycle start the carrier steps with the values being shadowed on this edge,
  // so the first period after reset or a top/mode change already has the new shape.
  assign w_top_eff  = w_load ? w_top_clamp : r_top;
  assign w_mode_eff = w_load ? mode : r_mode;
  assign w_dir_eff  = w_load ? 1'b1 : r_dir;

  always_comb begin
    w_w_next   = r_w;
    w_dir_next = w_dir_eff;
    if (w_mode_eff) begin
      w_dir_next = 1'b1;
      w_w_next   = (r_w >= w_top_eff) ? '0 : r_w + 1'b1;
    end else begin
      if (w_dir_eff && (r_w < w_top_eff)) begin
        w_w_next = r_w + 1'b1;
      end else begin
        w_w_next = r_w - 1'b1;
      end
      if (w_w_next == w_top_eff) begin
        w_dir_next = 1'b0;
      end else if (w_w_next == '0) begin
        w_dir_next = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cmp
    logic [WIDTH-1:0] w_d;
    assign w_d       = r_duty[k*WIDTH +: WIDTH];
    // Subtraction only matters when d > dead_i; the AND masks the wrapped case.
    assign w_hi_c[k] = r_en[k] & (w_d > r_dead) & ((w_d - r_dead) > r_w);
    assign w_lo_c[k] = r_en[k] & (w_d <= r_w);
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_w       <= '0;
      r_dir     <= 1'b1;
      r_top     <= '0;
      r_mode    <= 1'b0;
      r_duty    <= '0;
      r_en      <= '0;
      r_dead    <= MIN_DEAD;
      r_hi      <= '0;
      r_lo      <= '0;
      r_faulted <= 1'b0;
    end else begin
      r_w    <= w_w_next;
      r_dir  <= w_dir_next;
      r_dead <= w_dead_clamp;
      if (w_load) begin
        r_top  <= w_top_clamp;
        r_mode <= mode;
        r_duty <= duty;
        r_en   <= en;
      end
      r_hi <= w_hi_c;
      r_lo <= w_lo_c;
      if (fault) begin
        r_faulted <= 1'b1;
      end else if (fault_clr) begin
        r_faulted <= 1'b0;
      end
    end
  end

  assign hi        = r_hi & ~r_lo & {N_CH{~r_faulted}};
  assign lo        = r_lo & {N_CH{~r_faulted}};
  assign w         = r_w;
  assign cyc_start = (r_w == '0);
  assign cyc_top   = (r_w == r_top);
  assign faulted   = r_faulted;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - directed vector bench for pwm_multi.
module tb_pwm_multi;

  logic c = 1'b0;
  always #5 c = ~c;

  logic          rst;
  logic [15:0]   w_top;
  logic          mode;
  logic [47:0]   duty;
  logic [2:0]    en;
  logic [15:0]   dead;
  logic          fault;
  logic          fault_clr;
  logic [2:0]    hi_a, lo_a, hi_b, lo_b;
  logic [15:0]   w_a, w_b;
  logic          cs_a, ct_a, cs_b, ct_b, f_a, f_b;

  pwm_multi #(.N_CH(3), .WIDTH(16), .MIN_DEAD(16'd1), .MIN_TOP(16'd2)) u_a (
    .c(c), .rst(rst), .w_top(w_top), .mode(mode), .duty(duty), .en(en), .dead(dead),
    .fault(fault), .fault_clr(fault_clr), .hi(hi_a), .lo(lo_a), .w(w_a),
    .cyc_start(cs_a), .cyc_top(ct_a), .faulted(f_a));

  pwm_multi #(.N_CH(3), .WIDTH(16), .MIN_DEAD(16'd4), .MIN_TOP(16'd2)) u_b (
    .c(c), .rst(rst), .w_top(w_top), .mode(mode), .duty(duty), .en(en), .dead(dead),
    .fault(fault), .fault_clr(fault_clr), .hi(hi_b), .lo(lo_b), .w(w_b),
    .cyc_start(cs_b), .cyc_top(ct_b), .faulted(f_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  always @(negedge c) begin
    if (!rst) begin
      check("overlap_a", {29'd0, hi_a & lo_a}, 32'd0);
      check("overlap_b", {29'd0, hi_b & lo_b}, 32'd0);
    end
  end

  typedef struct {
    bit               inst;
    logic             mode;
    logic [15:0]      top_in;
    logic [15:0]      top_eff;
    logic [2:0][15:0] d;
    logic [15:0]      dead;
    logic [2:0]       en;
    logic [2:0][15:0] hi_lt;
    logic [2:0][15:0] lo_ge;
    int               period;
  } vec_t;

  function automatic vec_t mk(bit inst, logic m, int ti, int te, int d0, int d1, int d2,
                              int dd, logic [2:0] e, int h0, int h1, int h2,
                              int l0, int l1, int l2, int per);
    vec_t v;
    v.inst = inst; v.mode = m; v.top_in = 16'(ti); v.top_eff = 16'(te);
    v.d[0] = 16'(d0); v.d[1] = 16'(d1); v.d[2] = 16'(d2);
    v.dead = 16'(dd); v.en = e;
    v.hi_lt[0] = 16'(h0); v.hi_lt[1] = 16'(h1); v.hi_lt[2] = 16'(h2);
    v.lo_ge[0] = 16'(l0); v.lo_ge[1] = 16'(l1); v.lo_ge[2] = 16'(l2);
    v.period = per;
    return v;
  endfunction

  function automatic logic [2:0] get_hi(bit i);
    return i ? hi_b : hi_a;
  endfunction
  function automatic logic [2:0] get_lo(bit i);
    return i ? lo_b : lo_a;
  endfunction
  function automatic logic [15:0] get_w(bit i);
    return i ? w_b : w_a;
  endfunction
  function automatic logic get_ct(bit i);
    return i ? ct_b : ct_a;
  endfunction

  task automatic wait_w(input bit i, input logic [15:0] val, input string name);
    bit hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge c);
      if (get_w(i) == val) hit = 1;
    end
    if (!hit) timeout(name);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] prev;
    logic [2:0]  eh, el;
    int          cnt;
    bit          done;
    mode = v.mode; w_top = v.top_in; dead = v.dead; en = v.en; duty = v.d;
    wait_w(v.inst, 16'd0, "sync0");
    wait_w(v.inst, 16'd0, "sync1");
    prev = get_w(v.inst);
    cnt  = 0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge c);
      cnt++;
      for (int ch = 0; ch < 3; ch++) begin
        eh[ch] = prev < v.hi_lt[ch];
        el[ch] = prev >= v.lo_ge[ch];
      end
      check($sformatf("v%0d_hi_w%0d", idx, prev), {29'd0, get_hi(v.inst)}, {29'd0, eh});
      check($sformatf("v%0d_lo_w%0d", idx, prev), {29'd0, get_lo(v.inst)}, {29'd0, el});
      check($sformatf("v%0d_cyc_top_w%0d", idx, get_w(v.inst)), {31'd0, get_ct(v.inst)},
            {31'd0, get_w(v.inst) == v.top_eff});
      prev = get_w(v.inst);
      if (prev == 16'd0) done = 1;
    end
    if (!done) timeout($sformatf("v%0d_period", idx));
    else check($sformatf("v%0d_period", idx), cnt, v.period);
  endtask

  vec_t vecs[6];

  initial begin
    logic [15:0] prev;
    logic [15:0] saved_w;
    int          cur_d;

    vecs[0] = mk(0, 0, 16, 16, 5, 4, 3,  1, 3'b111, 4, 3, 2,  5, 4, 3,  32);
    vecs[1] = mk(0, 1, 9,  9,  4, 0, 12, 1, 3'b111, 3, 0, 11, 4, 0, 12, 10);
    vecs[2] = mk(0, 0, 8,  8,  2, 6, 8,  2, 3'b101, 0, 0, 6,  2, 16'hFFFF, 8, 16);
    vecs[3] = mk(0, 1, 0,  2,  1, 2, 3,  1, 3'b111, 0, 1, 2,  1, 2, 3,  3);
    vecs[4] = mk(1, 1, 10, 10, 3, 3, 3,  0, 3'b111, 0, 0, 0,  3, 3, 3,  11);
    vecs[5] = mk(1, 0, 0,  2,  1, 2, 0,  0, 3'b111, 0, 0, 0,  1, 2, 0,  4);

    rst = 1'b1; w_top = 16'd16; mode = 1'b0; duty = '0; en = '0; dead = 16'd1;
    fault = 1'b0; fault_clr = 1'b0;
    #3;
    check("rst_w", {16'd0, w_a}, 32'd0);
    check("rst_hi", {29'd0, hi_a}, 32'd0);
    check("rst_lo", {29'd0, lo_a}, 32'd0);
    check("rst_faulted", {31'd0, f_a}, 32'd0);
    check("rst_cyc_start", {31'd0, cs_a}, 32'd1);
    @(negedge c);
    @(negedge c);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // duty change mid-cycle takes effect only after the next w==0
    run_vec(vecs[0], 6);
    wait_w(0, 16'd7, "wait_w7");
    duty[15:0] = 16'd10;
    cur_d = 5;
    prev  = w_a;
    for (int k = 0; k < 40; k++) begin
      @(negedge c);
      check($sformatf("shadow_hi_d%0d_w%0d", cur_d, prev), {31'd0, hi_a[0]},
            {31'd0, int'(prev) < cur_d - 1});
      check($sformatf("shadow_lo_d%0d_w%0d", cur_d, prev), {31'd0, lo_a[0]},
            {31'd0, int'(prev) >= cur_d});
      if (prev == 16'd0) cur_d = 10;
      prev = w_a;
    end

    // fault latch, carrier keeps running, set wins over clear
    wait_w(0, 16'd12, "wait_w12");
    fault = 1'b1;
    @(negedge c);
    fault = 1'b0;
    check("fault_set", {31'd0, f_a}, 32'd1);
    check("fault_hi", {29'd0, hi_a}, 32'd0);
    check("fault_lo", {29'd0, lo_a}, 32'd0);
    saved_w = w_a;
    repeat (5) @(negedge c);
    check("fault_hold", {31'd0, f_a}, 32'd1);
    check("fault_hold_lo", {29'd0, lo_a}, 32'd0);
    check("fault_carrier_runs", {31'd0, w_a != saved_w}, 32'd1);
    fault = 1'b1; fault_clr = 1'b1;
    @(negedge c);
    fault = 1'b0;
    check("fault_set_wins", {31'd0, f_a}, 32'd1);
    prev = w_a;
    @(negedge c);
    fault_clr = 1'b0;
    check("fault_cleared", {31'd0, f_a}, 32'd0);
    check("fault_restore_hi", {31'd0, hi_a[0]}, {31'd0, prev < 16'd9});
    check("fault_restore_lo", {31'd0, lo_a[0]}, {31'd0, prev >= 16'd10});

    // asynchronous reset mid-cycle
    wait_w(0, 16'd11, "wait_w11");
    check("pre_rst_lo", {31'd0, lo_a[0]}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_w", {16'd0, w_a}, 32'd0);
    check("arst_hi", {29'd0, hi_a}, 32'd0);
    check("arst_lo", {29'd0, lo_a}, 32'd0);
    check("arst_faulted", {31'd0, f_a}, 32'd0);
    @(negedge c);
    rst = 1'b0;
    @(negedge c);
    check("post_rst_w", {16'd0, w_a}, 32'd1);
    check("post_rst_hi", {29'd0, hi_a}, 32'd0);
    check("post_rst_lo", {29'd0, lo_a}, 32'd0);
    wait_w(0, 16'd16, "post_rst_top");
    check("post_rst_cyc_top", {31'd0, ct_a}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
